mdu_arbiter: RTL and testbench

- Shared multiply/divide unit for the two EX pipes (slot 0 = older, slot 1 = younger).
- Arbitrates MULT/MULTU/DIV/DIVU requests from both pipes and sequences a pipelined multiplier and an iterative restoring divider.
- Drives the EX stall request and returns hi/lo results tagged with the owning pipe, for hilo write and forwarding.

---
 rtl/mdu_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_mdu_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_arbiter.sv
// Shared multiply/divide unit for the two EX pipes: fixed-priority arbitration,
// pipelined multiplier, iterative restoring divider. Optional: MDU_EARLY_DIV_EN.
module mdu_arbiter #(
  parameter int unsigned MUL_LAT = 2,
  parameter int unsigned DIV_BPC = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        req0_valid,
  input  logic [1:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  input  logic [1:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        grant0,
  output logic        grant1,
  output logic        busy,
  output logic        stall_req,
  output logic        res_valid,
  output logic        res_owner,
  output logic [31:0] hi_res,
  output logic [31:0] lo_res
);

  localparam int unsigned XLEN     = 32;
  localparam int unsigned CNT_W    = 6;
  localparam int unsigned DIV_ITER = XLEN / DIV_BPC;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

  state_e state_q, state_d;

  logic              cmp0_q, cmp1_q, cmp0_eff, cmp1_eff;
  logic              pend0, pend1;
  logic              owner_q;
  logic              neg_quo_q, neg_rem_q, div0_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   a_q, rem_q, quo_q, dvs_q, res_hi_q, res_lo_q;

  logic [1:0]        sel_op;
  logic [XLEN-1:0]   sel_a, sel_b, a_mag, b_mag;
  logic              sel_signed, early_div;
  logic [2*XLEN-1:0] mul_ax, mul_bx, product;
  logic [XLEN:0]     step_t;
  logic [XLEN-1:0]   step_r, step_q, fin_hi, fin_lo;

  assign pend0 = req0_valid & ~cmp0_q;
  assign pend1 = req1_valid & ~cmp1_q;

  // Operand selection follows the arbitration winner (pipe 0 first).
  assign sel_op     = pend0 ? req0_op : req1_op;
  assign sel_a      = pend0 ? req0_a  : req1_a;
  assign sel_b      = pend0 ? req0_b  : req1_b;
  assign sel_signed = ~sel_op[0];
  assign a_mag      = (sel_signed && sel_a[XLEN-1]) ? -sel_a : sel_a;
  assign b_mag      = (sel_signed && sel_b[XLEN-1]) ? -sel_b : sel_b;

`ifdef MDU_EARLY_DIV_EN
  assign early_div = (b_mag == '0) || (a_mag < b_mag);
`else
  assign early_div = 1'b0;
`endif

  // Sign/zero extension makes one 64x64 truncated product serve MULT and MULTU.
  assign mul_ax  = sel_op[0] ? {{XLEN{1'b0}}, sel_a} : {{XLEN{sel_a[XLEN-1]}}, sel_a};
  assign mul_bx  = sel_op[0] ? {{XLEN{1'b0}}, sel_b} : {{XLEN{sel_b[XLEN-1]}}, sel_b};
  assign product = mul_ax * mul_bx;

  // Restoring divide steps retired this cycle.
  always_comb begin
    step_r = rem_q;
    step_q = quo_q;
    step_t = '0;
    for (int i = 0; i < int'(DIV_BPC); i++) begin
      step_t = {step_r, step_q[XLEN-1]};
      step_q = {step_q[XLEN-2:0], 1'b0};
      if (step_t >= {1'b0, dvs_q}) begin
        step_t    = step_t - {1'b0, dvs_q};
        step_q[0] = 1'b1;
      end
      step_r = step_t[XLEN-1:0];
    end
  end

  // Sign fix; divide-by-zero returns the raw dividend and all-ones quotient.
  always_comb begin
    fin_hi = neg_rem_q ? -step_r : step_r;
    fin_lo = neg_quo_q ? -step_q : step_q;
    if (div0_q) begin
      fin_hi = a_q;
      fin_lo = '1;
    end
  end

  assign cmp0_eff  = cmp0_q | (res_valid & ~res_owner);
  assign cmp1_eff  = cmp1_q | (res_valid &  res_owner);
  assign stall_req = (req0_valid & ~cmp0_eff) | (req1_valid & ~cmp1_eff);
  assign busy      = (state_q != IDLE);
  assign res_owner = owner_q;
  assign hi_res    = res_hi_q;
  assign lo_res    = res_lo_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    grant0    = 1'b0;
    grant1    = 1'b0;
    res_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (rst && !flush && (pend0 || pend1)) begin
          grant0 = pend0;
          grant1 = ~pend0;
          if (!sel_op[1])     state_d = (MUL_LAT == 1) ? DONE : MUL;
          else if (early_div) state_d = DONE;
          else                state_d = DIV;
        end
      end
      MUL:  if (cnt_q <= CNT_W'(1)) state_d = DONE;
      DIV:  if (cnt_q == CNT_W'(1)) state_d = DONE;
      DONE: begin
        res_valid = ~flush;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // Completion flags, operand latches and the mul/div datapath.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmp0_q    <= 1'b0;
      cmp1_q    <= 1'b0;
      owner_q   <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      cnt_q     <= '0;
      a_q       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      res_hi_q  <= '0;
      res_lo_q  <= '0;
    end else begin
      // Clearing wins: once the pipe advances a held valid is a new instruction.
      if (flush || !stall_req) begin
        cmp0_q <= 1'b0;
        cmp1_q <= 1'b0;
      end else if (res_valid) begin
        if (owner_q) cmp1_q <= 1'b1;
        else         cmp0_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (grant0 || grant1) begin
            owner_q   <= grant1;
            a_q       <= sel_a;
            neg_quo_q <= sel_signed & (sel_a[XLEN-1] ^ sel_b[XLEN-1]);
            neg_rem_q <= sel_signed & sel_a[XLEN-1];
            div0_q    <= (sel_b == '0);
            rem_q     <= '0;
            quo_q     <= a_mag;
            dvs_q     <= b_mag;
            if (!sel_op[1]) begin
              {res_hi_q, res_lo_q} <= product;
              cnt_q                <= CNT_W'(MUL_LAT - 1);
            end else begin
              cnt_q    <= CNT_W'(DIV_ITER);
              res_hi_q <= sel_a;
              res_lo_q <= (sel_b == '0) ? '1 : '0;
            end
          end
        end
        MUL: cnt_q <= cnt_q - CNT_W'(1);
        DIV: begin
          rem_q <= step_r;
          quo_q <= step_q;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            res_hi_q <= fin_hi;
            res_lo_q <= fin_lo;
          end
        end
        default: ;
      endcase

      if (flush) cnt_q <= '0;
    end
  end

endmodule

// File: tb/tb_mdu_arbiter.sv
// Directed self-checking bench for mdu_arbiter (MUL_LAT=2, DIV_BPC=1).
module tb_mdu_arbiter;

  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;
`ifdef MDU_EARLY_DIV_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        req0_valid, req1_valid;
  logic [1:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        grant0, grant1, busy, stall_req, res_valid, res_owner;
  logic [31:0] hi_res, lo_res;

  int checks = 0;
  int failures = 0;

  mdu_arbiter #(.MUL_LAT(2), .DIV_BPC(1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .grant0(grant0), .grant1(grant1), .busy(busy), .stall_req(stall_req),
    .res_valid(res_valid), .res_owner(res_owner), .hi_res(hi_res), .lo_res(lo_res)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    int          lat;
    bit          early;
  } vec_t;

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({busy, res_valid, grant0, grant1, stall_req, res_owner} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=000000", {busy, res_valid, grant0, grant1, stall_req, res_owner});
    end
    checks++;
    if ({hi_res, lo_res} !== 64'h0) begin
      failures++; $display("FAIL reset_data got=%h exp=0", {hi_res, lo_res});
    end
    next_cycle(); next_cycle();
    rst = 1'b1;
    next_cycle();
  endtask

  task automatic test_mul_basic();
    req0_valid = 1'b1; req0_op = OP_MULT; req0_a = 32'hFFFFFFFE; req0_b = 32'd3;
    @(negedge clk);
    checks++;
    if ({grant0, grant1, stall_req} !== 3'b101) begin
      failures++; $display("FAIL mul_grant got=%b exp=101", {grant0, grant1, stall_req});
    end
    next_cycle(); @(negedge clk);
    checks++;
    if ({res_valid, stall_req, busy} !== 3'b011) begin
      failures++; $display("FAIL mul_t1 got=%b exp=011", {res_valid, stall_req, busy});
    end
    next_cycle(); @(negedge clk);
    checks++;
    if ({res_valid, res_owner, stall_req} !== 3'b100 || hi_res !== 32'hFFFFFFFF || lo_res !== 32'hFFFFFFFA) begin
      failures++;
      $display("FAIL mul_result got=%b %h_%h exp=100 ffffffff_fffffffa", {res_valid, res_owner, stall_req}, hi_res, lo_res);
    end
    next_cycle(); req0_valid = 1'b0; @(negedge clk);
    checks++;
    if ({busy, res_valid, grant0} !== 3'b000) begin
      failures++; $display("FAIL mul_idle got=%b exp=000", {busy, res_valid, grant0});
    end
  endtask

  task automatic test_arbitration();
    next_cycle();
    req0_valid = 1'b1; req0_op = OP_DIVU;  req0_a = 32'd100;     req0_b = 32'd7;
    req1_valid = 1'b1; req1_op = OP_MULTU; req1_a = 32'h10000;   req1_b = 32'h10000;
    @(negedge clk);
    checks++;
    if ({grant0, grant1} !== 2'b10) begin
      failures++; $display("FAIL arb_grant0 got=%b exp=10", {grant0, grant1});
    end
    for (int k = 1; k <= 32; k++) begin
      next_cycle(); @(negedge clk);
      checks++;
      if ({res_valid, stall_req, grant1} !== 3'b010) begin
        failures++; $display("FAIL arb_wait cyc=%0d got=%b exp=010", k, {res_valid, stall_req, grant1});
      end
    end
    next_cycle(); @(negedge clk);
    checks++;
    if ({res_valid, res_owner, stall_req} !== 3'b101 || hi_res !== 32'd2 || lo_res !== 32'd14) begin
      failures++;
      $display("FAIL arb_div_result got=%b %h_%h exp=101 00000002_0000000e", {res_valid, res_owner, stall_req}, hi_res, lo_res);
    end
    next_cycle(); @(negedge clk);
    checks++;
    if ({grant0, grant1, res_valid, stall_req} !== 4'b0101) begin
      failures++; $display("FAIL arb_grant1 got=%b exp=0101", {grant0, grant1, res_valid, stall_req});
    end
    next_cycle(); @(negedge clk);
    checks++;
    if ({res_valid, stall_req} !== 2'b01) begin
      failures++; $display("FAIL arb_t35 got=%b exp=01", {res_valid, stall_req});
    end
    next_cycle(); @(negedge clk);
    checks++;
    if ({res_valid, res_owner, stall_req} !== 3'b110 || hi_res !== 32'd1 || lo_res !== 32'd0) begin
      failures++;
      $display("FAIL arb_mul_result got=%b %h_%h exp=110 00000001_00000000", {res_valid, res_owner, stall_req}, hi_res, lo_res);
    end
    next_cycle(); req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_vectors();
    vec_t v[10];
    v[0] = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33, 1'b0};
    v[1] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 33, 1'b0};
    v[2] = '{OP_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 33, 1'b1};
    v[3] = '{OP_DIVU,  32'd3,        32'd9,        32'd3,        32'd0,        33, 1'b1};
    v[4] = '{OP_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 33, 1'b1};
    v[5] = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 33, 1'b0};
    v[6] = '{OP_DIV,   32'hFFFFFFFE, 32'd5,        32'hFFFFFFFE, 32'd0,        33, 1'b1};
    v[7] = '{OP_DIVU,  32'hFFFFFFFF, 32'd2,        32'd1,        32'h7FFFFFFF, 33, 1'b0};
    v[8] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h0,        2,  1'b0};
    v[9] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 2,  1'b0};
    for (int i = 0; i < 10; i++) begin
      int c;
      int exp_lat;
      exp_lat = (EARLY && v[i].early) ? 1 : v[i].lat;
      next_cycle();
      req0_valid = 1'b1; req0_op = v[i].op; req0_a = v[i].a; req0_b = v[i].b;
      @(negedge clk);
      checks++;
      if (grant0 !== 1'b1) begin
        failures++; $display("FAIL vec%0d_grant got=%b exp=1", i, grant0);
      end
      c = 0;
      do begin
        next_cycle(); @(negedge clk); c++;
      end while (res_valid !== 1'b1 && c < 50);
      checks++;
      if (c != exp_lat) begin
        failures++; $display("FAIL vec%0d_latency got=%0d exp=%0d", i, c, exp_lat);
      end
      checks++;
      if (hi_res !== v[i].hi || lo_res !== v[i].lo || res_owner !== 1'b0 || stall_req !== 1'b0) begin
        failures++;
        $display("FAIL vec%0d_result got=%h_%h own=%b stall=%b exp=%h_%h own=0 stall=0",
                 i, hi_res, lo_res, res_owner, stall_req, v[i].hi, v[i].lo);
      end
      next_cycle(); req0_valid = 1'b0; @(negedge clk);
      checks++;
      if ({res_valid, busy} !== 2'b00) begin
        failures++; $display("FAIL vec%0d_after got=%b exp=00", i, {res_valid, busy});
      end
    end
  endtask

  task automatic test_flush();
    next_cycle();
    req0_valid = 1'b1; req0_op = OP_DIVU; req0_a = 32'd100; req0_b = 32'd7;
    @(negedge clk);
    checks++;
    if (grant0 !== 1'b1) begin
      failures++; $display("FAIL flush_div_grant got=%b exp=1", grant0);
    end
    for (int k = 1; k <= 9; k++) next_cycle();
    next_cycle();
    flush = 1'b1; req0_op = OP_MULTU; req0_a = 32'd6; req0_b = 32'd7;
    @(negedge clk);
    checks++;
    if ({grant0, res_valid} !== 2'b00) begin
      failures++; $display("FAIL flush_cycle got=%b exp=00", {grant0, res_valid});
    end
    next_cycle(); flush = 1'b0; @(negedge clk);
    checks++;
    if ({busy, grant0, res_valid} !== 3'b010) begin
      failures++; $display("FAIL flush_regrant got=%b exp=010", {busy, grant0, res_valid});
    end
    next_cycle(); @(negedge clk);
    checks++;
    if (res_valid !== 1'b0) begin
      failures++; $display("FAIL flush_no_stale got=%b exp=0", res_valid);
    end
    next_cycle(); @(negedge clk);
    checks++;
    if (res_valid !== 1'b1 || hi_res !== 32'd0 || lo_res !== 32'd42) begin
      failures++; $display("FAIL flush_new_result got=%b %h_%h exp=1 00000000_0000002a", res_valid, hi_res, lo_res);
    end
    next_cycle(); req0_valid = 1'b0;
    // Flush while idle blocks the grant for one cycle only.
    next_cycle();
    flush = 1'b1; req0_valid = 1'b1; req0_op = OP_MULT; req0_a = 32'd3; req0_b = 32'd4;
    @(negedge clk);
    checks++;
    if (grant0 !== 1'b0) begin
      failures++; $display("FAIL flush_idle_nogrant got=%b exp=0", grant0);
    end
    next_cycle(); flush = 1'b0; @(negedge clk);
    checks++;
    if (grant0 !== 1'b1) begin
      failures++; $display("FAIL flush_idle_grant got=%b exp=1", grant0);
    end
    next_cycle();
    next_cycle(); flush = 1'b1; @(negedge clk);
    checks++;
    if ({res_valid, busy} !== 2'b01) begin
      failures++; $display("FAIL flush_done_suppress got=%b exp=01", {res_valid, busy});
    end
    next_cycle(); flush = 1'b0; req0_valid = 1'b0; @(negedge clk);
    checks++;
    if ({res_valid, busy, grant0} !== 3'b000) begin
      failures++; $display("FAIL flush_done_after got=%b exp=000", {res_valid, busy, grant0});
    end
  endtask

  task automatic test_drop_valid();
    next_cycle();
    req0_valid = 1'b1; req0_op = OP_MULT; req0_a = 32'd2; req0_b = 32'd3;
    next_cycle(); req0_valid = 1'b0;
    next_cycle(); @(negedge clk);
    checks++;
    if (res_valid !== 1'b1 || lo_res !== 32'd6 || stall_req !== 1'b0) begin
      failures++; $display("FAIL drop_valid got=%b %h stall=%b exp=1 00000006 stall=0", res_valid, lo_res, stall_req);
    end
  endtask

  task automatic test_reset_mid_div();
    next_cycle();
    req0_valid = 1'b1; req0_op = OP_DIVU; req0_a = 32'd1000; req0_b = 32'd3;
    for (int k = 1; k <= 4; k++) next_cycle();
    next_cycle();
    rst = 1'b0; req0_valid = 1'b0;
    #1;
    checks++;
    if ({busy, res_valid, grant0, grant1} !== 4'b0000) begin
      failures++; $display("FAIL rst_async got=%b exp=0000", {busy, res_valid, grant0, grant1});
    end
    @(negedge clk);
    checks++;
    if ({busy, res_valid, grant0, grant1, stall_req} !== 5'b00000) begin
      failures++; $display("FAIL rst_edge got=%b exp=00000", {busy, res_valid, grant0, grant1, stall_req});
    end
    next_cycle(); rst = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      checks++;
      if ({res_valid, busy} !== 2'b00) begin
        failures++; $display("FAIL rst_quiet cyc=%0d got=%b exp=00", k, {res_valid, busy});
      end
      next_cycle();
    end
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0;
    req0_valid = 1'b0; req0_op = 2'b00; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = 2'b00; req1_a = '0; req1_b = '0;
    test_reset();
    test_mul_basic();
    test_arbitration();
    test_vectors();
    test_flush();
    test_drop_valid();
    test_reset_mid_div();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
